// File: rtl/nn_frame_scheduler.sv
// Frame scheduler for the fixed-latency NN datapath: credit-gated launch, tag
// tracking through the pipeline, FWFT result FIFO and flush/drain control.
module nn_frame_scheduler #(
  parameter int WIDTH          = 16,
  parameter int SYS_INPUT_SIZE = 10,
  parameter int PIPE_LATENCY   = 8,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic signed [WIDTH*SYS_INPUT_SIZE-1:0] s_data,
  output logic [WIDTH*SYS_INPUT_SIZE-1:0]      nn_in_data,
  input  logic [WIDTH-1:0]                     nn_out_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [WIDTH-1:0]                     m_data,
  input  logic                                 flush,
  output logic                                 flush_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      inflight,
  output logic [15:0]                          result_count,
  output logic                                 err_overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [PIPE_LATENCY:0] tag;
  logic [CW-1:0]     fifo_count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [CW:0]       occupancy;
  logic              accept, push, push_ok, pop, full;

  // Credits = FIFO_DEPTH - fifo_count - inflight; s_ready needs at least one.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign s_ready   = !rst && (state == RUN) && (occupancy < (CW+1)'(FIFO_DEPTH));

  assign accept  = s_valid && s_ready;
  assign push    = tag[PIPE_LATENCY];
  assign full    = (fifo_count == CW'(FIFO_DEPTH));
  assign push_ok = push && !full;
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      tag          <= '0;
      nn_in_data   <= '0;
      inflight     <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      result_count <= '0;
      err_overflow <= 1'b0;
    end else begin
      state <= state_next;
      tag   <= {tag[PIPE_LATENCY-1:0], accept};
      if (accept) nn_in_data <= s_data;

      case ({accept, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (push && full) err_overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        result_count <= result_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= nn_out_data;
  end

  always_comb begin
    state_next = state;
    flush_done = 1'b0;
    case (state)
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   if (inflight == '0 && fifo_count == '0) state_next = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_nn_frame_scheduler.sv
// Self-checking bench for nn_frame_scheduler: behavioural datapath model plus a
// scoreboard of expected results pushed on accept and compared on pop.
module tb_nn_frame_scheduler;

  localparam int W  = 16;
  localparam int N  = 10;
  localparam int L  = 8;
  localparam int D  = 8;

  logic           clk, rst;
  logic           s_valid, s_ready;
  logic [W*N-1:0] s_data, nn_in_data;
  logic [W-1:0]   nn_out_data, m_data;
  logic           m_valid, m_ready, flush, flush_done, err_overflow;
  logic [3:0]     inflight;
  logic [15:0]    result_count;

  nn_frame_scheduler #(
    .WIDTH(W), .SYS_INPUT_SIZE(N), .PIPE_LATENCY(L), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .nn_in_data(nn_in_data), .nn_out_data(nn_out_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .flush(flush), .flush_done(flush_done),
    .inflight(inflight), .result_count(result_count), .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W*N-1:0] v);
    logic [W-1:0] acc;
    acc = 16'h5A5A;
    for (int i = 0; i < N; i++) acc = {acc[14:0], acc[15]} ^ v[i*W +: W];
    return acc;
  endfunction

  // Datapath stand-in: L register stages, output reflects nn_in_data L cycles later.
  logic [W-1:0] dp [L];
  always_ff @(posedge clk) begin
    dp[0] <= model(nn_in_data);
    for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
  end
  assign nn_out_data = dp[L-1];

  int           n_checks = 0, n_fail = 0;
  int           cyc = 0, n_acc = 0, n_pop = 0, n_fd = 0;
  int           fd_cyc = -1, last_pop_cyc = -1, peak = 0;
  logic [W-1:0] exp_q[$];
  logic [W*N-1:0] last_data, fixed_data;
  logic         use_fixed = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic mr, input logic fl = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    s_valid = v;
    m_ready = mr;
    flush   = fl;
    rst     = r;
    s_data  = use_fixed ? fixed_data : {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    cyc++;
    if (r) begin
      exp_q.delete();
      n_pop = 0;
    end else begin
      if (s_valid && s_ready) begin
        exp_q.push_back(model(s_data));
        last_data = s_data;
        n_acc++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("stale_result", 32'd1, 32'd0);
        else check("m_data", m_data, exp_q.pop_front());
        n_pop++;
        last_pop_cyc = cyc;
      end
      if (flush_done) begin
        n_fd++;
        fd_cyc = cyc;
      end
      if (int'(inflight) > peak) peak = int'(inflight);
    end
  endtask

  initial begin
    int start, mv_cyc, ca, t, p0;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0; s_data = '0;
    fixed_data = {N{16'h0100}};

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("rst_s_ready", s_ready, 0);
    step(0, 1);
    check("rst_release_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_inflight", inflight, 0);
    check("rst_result_count", result_count, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_nn_in_data", nn_in_data == '0, 1);

    // Single vector latency
    use_fixed = 1'b1;
    step(1, 1);
    use_fixed = 1'b0;
    ca = cyc;
    check("single_accept", n_acc, 1);
    mv_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 1);
      if (i == 0) begin
        check("single_inflight", inflight, 1);
        check("single_nn_in_data", nn_in_data == last_data, 1);
      end
      if (m_valid && mv_cyc < 0) mv_cyc = cyc;
    end
    check("single_latency", mv_cyc - ca, L + 2);
    check("single_result_count", result_count, 1);

    // Streaming 100 vectors
    start = n_acc;
    peak  = 0;
    for (int i = 0; i < 400 && (n_acc - start) < 100; i++) step(1, 1);
    check("stream_accepts", n_acc - start, 100);
    for (int i = 0; i < 40; i++) step(0, 1);
    check("stream_inflight_peak", peak, D);
    check("stream_drained", exp_q.size(), 0);
    check("stream_result_count", result_count, 16'(n_pop));
    check("stream_err_overflow", err_overflow, 0);

    // Backpressure
    start = n_acc;
    for (int i = 0; i < 30; i++) step(1, 0);
    check("bp_accepts", n_acc - start, D);
    check("bp_s_ready_low", s_ready, 0);
    p0 = n_pop;
    step(0, 1);
    check("bp_one_pop", n_pop - p0, 1);
    step(1, 0);
    check("bp_s_ready_after_pop", s_ready, 1);
    for (int i = 0; i < 20; i++) step(1, 0);
    check("bp_accepts_after_pop", n_acc - start, D + 1);
    for (int i = 0; i < 40; i++) step(0, 1);
    check("bp_drained", exp_q.size(), 0);
    check("bp_err_overflow", err_overflow, 0);

    // Flush under load (accept in the flush cycle is honoured)
    n_fd = 0; fd_cyc = -1;
    start = n_acc;
    for (int i = 0; i < 5; i++) step(1, 1);
    step(1, 1, 1);
    check("flush_accept_honoured", n_acc - start, 6);
    step(0, 1);
    check("flush_s_ready_low", s_ready, 0);
    for (int i = 0; i < 40 && n_fd == 0; i++) step(0, 1);
    check("flush_done_once", n_fd, 1);
    check("flush_done_timing", fd_cyc - last_pop_cyc, 2);
    check("flush_all_delivered", exp_q.size(), 0);
    step(0, 1);
    check("flush_back_to_run", s_ready, 1);
    check("flush_done_cleared", flush_done, 0);

    // Idle flush timing
    step(0, 1, 1);
    t = cyc;
    step(0, 1);
    check("idle_flush_drain", s_ready, 0);
    step(0, 1);
    check("idle_flush_done", flush_done, 1);
    step(0, 1);
    check("idle_flush_run", s_ready, 1);
    check("idle_flush_cycles", cyc - t, 3);

    // Reset mid-stream: 4 in flight, 3 in FIFO
    for (int i = 0; i < 7; i++) step(1, 0);
    for (int i = 0; i < 20 && inflight != 4'd4; i++) step(0, 0);
    check("mid_inflight_before", inflight, 4);
    check("mid_m_valid_before", m_valid, 1);
    step(0, 0, 0, 1);
    check("mid_rst_s_ready", s_ready, 0);
    step(0, 1);
    check("mid_m_valid", m_valid, 0);
    check("mid_inflight", inflight, 0);
    check("mid_result_count", result_count, 0);
    for (int i = 0; i < 20; i++) step(0, 1);
    check("mid_no_stale", n_pop, 0);
    check("final_err_overflow", err_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
